logo_scan_ctrl: RTL and testbench
=================================

# logo_scan_ctrl

Column scanner that sequences the logo bitmap ROM for the wave-logo display. It steps the ROM column index across the image and registers each 38-bit column, vertically shifted by a per-column triangle-wave offset. It then hands the column to the downstream LED/column driver over a valid/ready handshake, with a programmable dwell. A per-frame phase advance makes the logo appear to ripple.

## Interface
- COLS, 251, number of image columns scanned (0..COLS-1)
- ROWS, 38, column height in bits
- WAVE_AMP, 2, peak row offset; 0 disables the wave
- DWELL, 4, idle cycles after each accepted column before the next fetch
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low; one clock, all state in this domain
- enable  in  1  run request, level-sensitive
- col_idx  out  10  column address to ROM
- rom_data  in  ROWS  ROM column for col_idx (combinational ROM)
- out_col  out  ROWS  shifted column to driver
- out_valid  out  1  out_col valid
- out_ready  in  1  driver accepts
- frame_done  out  1  one-cycle pulse, last column accepted
- phase  out  log2(4*WAVE_AMP), min 1  current wave phase
- busy  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, FETCH, LATCH, PRESENT, HOLD.
- IDLE: when enable=1, go to FETCH; col_idx holds its value.
- FETCH: col_idx stable for one cycle so the ROM can settle; go to LATCH.
- LATCH: sample rom_data, apply offset, load out_col; go to PRESENT with out_valid=1.
- PRESENT: hold out_valid and out_col stable until out_ready=1.
  - On handshake: if col_idx=COLS-1, pulse frame_done, set col_idx=0, and advance phase=(phase+1) mod 4*WAVE_AMP; otherwise col_idx+1.
  - Go to HOLD, or straight to the next state if DWELL=0.
- HOLD: count DWELL cycles, then FETCH if enable=1, else IDLE.
- enable low is sampled only at column boundaries (end of HOLD or at the handshake when DWELL=0). A column in flight is always completed; valid is never retracted.
- Offset: u=(col_idx+phase) mod 4A, where A=WAVE_AMP.
  - off = u-A if u<2A, else 3A-u; range -A..+A.
  - off>0: out_col = rom_data >> off.
  - off<0: out_col = (rom_data << -off) truncated to ROWS bits.
  - Zero fill in both directions. A=0 forces off=0.
- col_idx addition is full width, with explicit wrap at COLS-1 (not at 2^10).

## Timing
- Reset values: col_idx=0, out_col=0, out_valid=0, frame_done=0, phase=0, busy=0, state=IDLE.
- Latency: enable high to out_valid high is 3 cycles (IDLE→FETCH→LATCH→PRESENT).
- Per column with out_ready held high: 3+DWELL cycles (FETCH, LATCH, PRESENT, DWELL×HOLD).
- out_ready high during FETCH or LATCH has no effect; only PRESENT consumes it.
- frame_done and phase update on the same edge as the final handshake.
- Reset mid-operation: immediate return to reset values; no partial column is presented after reset release.
- Simultaneous handshake on column COLS-1 and enable low: frame_done still pulses, col_idx wraps to 0, FSM ends in IDLE.

## Structure
- Shared package logo_pkg: ROWS, COLS, state enum type, col_t (10-bit) and row_t (ROWS-bit) typedefs.
- One sub-module, wave_shift: combinational offset computation and shift from (col_idx, phase, rom_data) to shifted column.
- Top holds the FSM, dwell counter, column and phase counters, and output registers.

## Test plan
- Reset then enable=1, out_ready=1, A=0, DWELL=0:
  - out_valid first high 3 cycles after enable.
  - out_col equals the ROM column for each col_idx 0..250.
  - frame_done pulses once per 753 cycles.
- A=2, phase=0, column 0 data 38'h1 << 10:
  - u=0 gives off=-2, so out_col = 1<<12.
  - Column 4 (u=4) gives off=+2, so out_col = data>>2.
  - After frame 1, phase=1 and column 0 uses off=-1.
- Backpressure: out_ready low for 20 cycles in PRESENT.
  - out_valid and out_col stay constant.
  - col_idx does not advance.
  - One handshake occurs when ready rises.
- DWELL=4: exactly 4 HOLD cycles (busy=1, out_valid=0) between consecutive valid columns.
- enable dropped mid-PRESENT on column 250:
  - Column still delivered; frame_done pulses; col_idx=0.
  - FSM reaches IDLE with busy=0.
- rst_n asserted during LATCH and during HOLD:
  - All outputs are at reset values asynchronously.
  - Restart begins at column 0, phase 0.

Source files
------------

// File: rtl/logo_scan_ctrl_pkg.sv
// Shared types and sizing for the wave-logo column scanner.
package logo_pkg;
  localparam int ROWS = 38;
  localparam int COLS = 251;

  typedef logic [9:0]      col_t;
  typedef logic [ROWS-1:0] row_t;

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, PRESENT, HOLD} state_t;

  // The phase counter must hold 0..4*amp-1, never narrower than one bit.
  function automatic int phase_w(input int amp);
    return (amp <= 0) ? 1 : $clog2(4 * amp);
  endfunction
endpackage

// File: rtl/logo_scan_ctrl_if.sv
// Column handshake between the scanner and the LED/column driver.
interface logo_scan_ctrl_if;
  import logo_pkg::*;

  row_t out_col;
  logic out_valid;
  logic out_ready;

  modport master (output out_col, output out_valid, input out_ready);
  modport slave  (input out_col, input out_valid, output out_ready);
endinterface

// File: rtl/logo_scan_ctrl_wave_shift.sv
// Triangle-wave vertical offset: maps (column, phase) to a signed shift
// and applies it to the ROM column with zero fill.
module wave_shift
  import logo_pkg::*;
#(
  parameter int WAVE_AMP = 2,
  parameter int PW       = phase_w(WAVE_AMP)
) (
  input  col_t          col_idx,
  input  logic [PW-1:0] phase,
  input  row_t          rom_data,
  output row_t          shifted
);
  localparam int          M    = (WAVE_AMP == 0) ? 1 : 4 * WAVE_AMP;
  localparam logic [15:0] A1   = 16'(WAVE_AMP);
  localparam logic [15:0] A2   = 16'(2 * WAVE_AMP);
  localparam logic [15:0] A3   = 16'(3 * WAVE_AMP);
  localparam logic [15:0] MODV = 16'(M);

  logic [15:0] w_u;
  logic [15:0] w_shl;
  logic [15:0] w_shr;

  assign w_u = (16'(col_idx) + 16'(phase)) % MODV;

  // Rising half of the wave covers off=-A..+A, falling half +A..-A.
  // With A=0 the modulus is 1, so both shift amounts collapse to zero.
  always_comb begin
    w_shl = '0;
    w_shr = '0;
    if (w_u < A2) begin
      if (w_u < A1) w_shl = A1 - w_u;
      else          w_shr = w_u - A1;
    end else begin
      if (w_u < A3) w_shr = A3 - w_u;
      else          w_shl = w_u - A3;
    end
  end

  assign shifted = (rom_data << w_shl) >> w_shr;
endmodule

// File: rtl/logo_scan_ctrl.sv
// Logo column scanner: steps the ROM column index, latches the wave-shifted
// column and presents it to the driver with a dwell gap between columns.
module logo_scan_ctrl
  import logo_pkg::*;
#(
  parameter  int COLS     = logo_pkg::COLS,
  parameter  int WAVE_AMP = 2,
  parameter  int DWELL    = 4,
  localparam int PW       = phase_w(WAVE_AMP)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  output col_t          col_idx,
  input  row_t          rom_data,
  logo_scan_ctrl_if.master drv,
  output logic          frame_done,
  output logic [PW-1:0] phase,
  output logic          busy
);
  localparam int M   = (WAVE_AMP == 0) ? 1 : 4 * WAVE_AMP;
  localparam int DCW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;

  state_t         r_state, w_state_next;
  col_t           r_col, w_col_next;
  logic [PW-1:0]  r_phase, w_phase_next;
  row_t           r_out_col, w_out_col_next;
  logic           r_out_valid, w_out_valid_next;
  logic           r_frame_done, w_frame_done_next;
  logic [DCW-1:0] r_dwell, w_dwell_next;
  row_t           w_shifted;

  wave_shift #(.WAVE_AMP(WAVE_AMP), .PW(PW)) u_wave_shift (
    .col_idx  (r_col),
    .phase    (r_phase),
    .rom_data (rom_data),
    .shifted  (w_shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_col        <= '0;
      r_phase      <= '0;
      r_out_col    <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_dwell      <= '0;
    end else begin
      r_state      <= w_state_next;
      r_col        <= w_col_next;
      r_phase      <= w_phase_next;
      r_out_col    <= w_out_col_next;
      r_out_valid  <= w_out_valid_next;
      r_frame_done <= w_frame_done_next;
      r_dwell      <= w_dwell_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_col_next        = r_col;
    w_phase_next      = r_phase;
    w_out_col_next    = r_out_col;
    w_out_valid_next  = r_out_valid;
    w_frame_done_next = 1'b0;
    w_dwell_next      = r_dwell;
    case (r_state)
      IDLE:  if (enable) w_state_next = FETCH;
      FETCH: w_state_next = LATCH;
      LATCH: begin
        w_out_col_next   = w_shifted;
        w_out_valid_next = 1'b1;
        w_state_next     = PRESENT;
      end
      PRESENT: begin
        if (drv.out_ready) begin
          w_out_valid_next = 1'b0;
          if (r_col == col_t'(COLS - 1)) begin
            w_col_next        = '0;
            w_frame_done_next = 1'b1;
            w_phase_next      = (r_phase == PW'(M - 1)) ? '0 : r_phase + 1'b1;
          end else begin
            w_col_next = r_col + 1'b1;
          end
          // enable is only honoured here and at the end of the dwell.
          if (DWELL != 0) begin
            w_dwell_next = '0;
            w_state_next = HOLD;
          end else begin
            w_state_next = enable ? FETCH : IDLE;
          end
        end
      end
      HOLD: begin
        if (r_dwell == DCW'(DWELL - 1)) w_state_next = enable ? FETCH : IDLE;
        else                            w_dwell_next = r_dwell + 1'b1;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign col_idx       = r_col;
  assign drv.out_col   = r_out_col;
  assign drv.out_valid = r_out_valid;
  assign frame_done    = r_frame_done;
  assign phase         = r_phase;
  assign busy          = (r_state != IDLE);
endmodule

// File: tb/tb_logo_scan_ctrl.sv
// Bench for logo_scan_ctrl: a flat no-wave/no-dwell instance and a
// wave/dwell instance, both checked against a spec-level model.
module tb_logo_scan_ctrl;
  import logo_pkg::*;

  localparam int NC = 251;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a, rst_n_b, en_a, en_b;
  logic [9:0]  col_a, col_b;
  logic [37:0] rd_a, rd_b;
  logic        fd_a, fd_b, busy_a, busy_b;
  logic        ph_a;
  logic [2:0]  ph_b;
  logic [37:0] rom [NC];
  logic [37:0] one;

  int errors = 0;
  int checks = 0;

  logo_scan_ctrl_if if_a ();
  logo_scan_ctrl_if if_b ();

  assign rd_a = (col_a < 10'(NC)) ? rom[col_a] : '0;
  assign rd_b = (col_b < 10'(NC)) ? rom[col_b] : '0;

  logo_scan_ctrl #(.WAVE_AMP(0), .DWELL(0)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .enable(en_a), .col_idx(col_a),
    .rom_data(rd_a), .drv(if_a), .frame_done(fd_a), .phase(ph_a), .busy(busy_a)
  );

  logo_scan_ctrl #(.WAVE_AMP(2), .DWELL(4)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .enable(en_b), .col_idx(col_b),
    .rom_data(rd_b), .drv(if_b), .frame_done(fd_b), .phase(ph_b), .busy(busy_b)
  );

  // Spec-level offset: triangle wave over 4A, negative offset shifts up.
  function automatic logic [37:0] ref_col(int col, int ph, int amp, logic [37:0] d);
    int u, off;
    logic [37:0] r;
    if (amp == 0) return d;
    u   = (col + ph) % (4 * amp);
    off = (u < 2 * amp) ? u - amp : 3 * amp - u;
    if (off >= 0) r = d >> off;
    else          r = d << (-off);
    return r;
  endfunction

  task automatic test_reset;
    rst_n_a = 0; rst_n_b = 0; en_a = 0; en_b = 0;
    if_a.out_ready = 0; if_b.out_ready = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({if_a.out_valid, fd_a, busy_a, ph_a, col_a, if_a.out_col} !== '0) begin
      errors++; $display("FAIL reset_a: got v=%b fd=%b busy=%b ph=%0d col=%0d oc=%0h required all zero",
        if_a.out_valid, fd_a, busy_a, ph_a, col_a, if_a.out_col);
    end
    checks++;
    if ({if_b.out_valid, fd_b, busy_b, ph_b, col_b, if_b.out_col} !== '0) begin
      errors++; $display("FAIL reset_b: got v=%b fd=%b busy=%b ph=%0d col=%0d oc=%0h required all zero",
        if_b.out_valid, fd_b, busy_b, ph_b, col_b, if_b.out_col);
    end
    rst_n_a = 1; rst_n_b = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({if_a.out_valid, busy_a, if_b.out_valid, busy_b} !== 4'b0) begin
      errors++; $display("FAIL idle_after_reset: got %b required 0000",
        {if_a.out_valid, busy_a, if_b.out_valid, busy_b});
    end
  endtask

  task automatic test_stream;
    int cyc, exp_col, nfd, first_fd, second_fd;
    logic exp_fd;
    en_a = 1; if_a.out_ready = 1;
    cyc = 0;
    while (!if_a.out_valid && cyc < 10) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc != 3) begin errors++; $display("FAIL latency_a: got %0d cycles required 3", cyc); end
    exp_col = 0; nfd = 0; first_fd = 0; second_fd = 0;
    for (int t = 0; t < 2000 && nfd < 2; t++) begin
      exp_fd = 1'b0;
      if (if_a.out_valid) begin
        checks++;
        if (col_a !== 10'(exp_col) || if_a.out_col !== rom[exp_col]) begin
          errors++; $display("FAIL stream_col: got col=%0d data=%0h required col=%0d data=%0h",
            col_a, if_a.out_col, exp_col, rom[exp_col]);
        end
        exp_fd  = (exp_col == NC - 1);
        exp_col = (exp_col + 1) % NC;
      end
      @(negedge clk);
      checks++;
      if (fd_a !== exp_fd) begin
        errors++; $display("FAIL stream_fd: got %b required %b at col %0d", fd_a, exp_fd, exp_col);
      end
      if (fd_a) begin
        if (nfd == 0) first_fd = t; else second_fd = t;
        nfd++;
      end
    end
    checks++;
    if (nfd != 2 || second_fd - first_fd != 753) begin
      errors++; $display("FAIL frame_period: got %0d pulses spaced %0d required 2 spaced 753",
        nfd, second_fd - first_fd);
    end
    en_a = 0;
    cyc = 0;
    while (busy_a && cyc < 10) begin @(negedge clk); cyc++; end
  endtask

  task automatic test_enable_drop;
    int cyc;
    rst_n_a = 0; @(negedge clk); rst_n_a = 1;
    en_a = 1; if_a.out_ready = 1;
    cyc = 0;
    while (!(if_a.out_valid && col_a == 10'd250) && cyc < 1000) begin @(negedge clk); cyc++; end
    if_a.out_ready = 0; en_a = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (if_a.out_valid !== 1'b1 || col_a !== 10'd250) begin
      errors++; $display("FAIL drop_hold: got v=%b col=%0d required v=1 col=250", if_a.out_valid, col_a);
    end
    if_a.out_ready = 1;
    @(negedge clk);
    if_a.out_ready = 0;
    checks++;
    if ({fd_a, busy_a, if_a.out_valid, col_a} !== {1'b1, 1'b0, 1'b0, 10'd0}) begin
      errors++; $display("FAIL drop_last: got fd=%b busy=%b v=%b col=%0d required fd=1 busy=0 v=0 col=0",
        fd_a, busy_a, if_a.out_valid, col_a);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({fd_a, busy_a, if_a.out_valid} !== 3'b000) begin
      errors++; $display("FAIL drop_idle: got fd/busy/v=%b required 000", {fd_a, busy_a, if_a.out_valid});
    end
  endtask

  task automatic test_wave;
    int col, ph, hs, gap;
    bit gap_active, rdy;
    logic exp_fd;
    rst_n_b = 0; if_b.out_ready = 0; @(negedge clk); rst_n_b = 1;
    en_b = 1;
    col = 0; ph = 0; hs = 0; gap = 0; gap_active = 0; exp_fd = 0;
    for (int t = 0; t < 6000 && hs < 254; t++) begin
      checks++;
      if (fd_b !== exp_fd) begin
        errors++; $display("FAIL wave_fd: got %b required %b (handshake %0d)", fd_b, exp_fd, hs);
      end
      exp_fd = 1'b0;
      rdy = ($urandom_range(3) != 0);
      if (if_b.out_valid) begin
        if (gap_active) begin
          checks++;
          if (gap != 6) begin errors++; $display("FAIL dwell_gap: got %0d idle cycles required 6", gap); end
          gap_active = 0;
        end
        checks++;
        if (col_b !== 10'(col) || ph_b !== 3'(ph) || if_b.out_col !== ref_col(col, ph, 2, rom[col])) begin
          errors++; $display("FAIL wave_col: got col=%0d ph=%0d data=%0h required col=%0d ph=%0d data=%0h",
            col_b, ph_b, if_b.out_col, col, ph, ref_col(col, ph, 2, rom[col]));
        end
        if (hs == 0 || hs == 4 || hs == 251) begin
          checks++;
          if (if_b.out_col !== ((hs == 0) ? one << 12 : (hs == 4) ? rom[4] >> 2 : one << 11)) begin
            errors++; $display("FAIL wave_point: got %0h at handshake %0d", if_b.out_col, hs);
          end
        end
        if (rdy) begin
          exp_fd = (col == NC - 1);
          col = (col + 1) % NC;
          if (col == 0) ph = (ph + 1) % 8;
          hs++; gap = 0; gap_active = 1;
        end
      end else if (gap_active) begin
        checks++;
        if (busy_b !== 1'b1) begin errors++; $display("FAIL dwell_busy: got %b required 1", busy_b); end
        gap++;
      end
      if_b.out_ready = rdy;
      @(negedge clk);
    end
    checks++;
    if (hs < 254 || ph_b !== 3'd1) begin
      errors++; $display("FAIL wave_progress: got %0d handshakes phase %0d required 254 phase 1", hs, ph_b);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    if_b.out_ready = 1;
    cyc = 0;
    while (!if_b.out_valid && cyc < 20) begin @(negedge clk); cyc++; end
    repeat (2) @(negedge clk);
    rst_n_b = 0;
    #1;
    checks++;
    if ({if_b.out_valid, fd_b, busy_b, ph_b, col_b, if_b.out_col} !== '0) begin
      errors++; $display("FAIL reset_hold: got v=%b busy=%b ph=%0d col=%0d oc=%0h required all zero",
        if_b.out_valid, busy_b, ph_b, col_b, if_b.out_col);
    end
    @(negedge clk); rst_n_b = 1;
    repeat (2) @(negedge clk);
    rst_n_b = 0;
    #1;
    checks++;
    if ({if_b.out_valid, fd_b, busy_b, ph_b, col_b, if_b.out_col} !== '0) begin
      errors++; $display("FAIL reset_latch: got v=%b busy=%b ph=%0d col=%0d oc=%0h required all zero",
        if_b.out_valid, busy_b, ph_b, col_b, if_b.out_col);
    end
    @(negedge clk); rst_n_b = 1;
    cyc = 0;
    while (!if_b.out_valid && cyc < 10) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc != 3 || col_b !== 10'd0 || ph_b !== 3'd0 || if_b.out_col !== one << 12) begin
      errors++; $display("FAIL restart: got lat=%0d col=%0d ph=%0d data=%0h required lat=3 col=0 ph=0 data=%0h",
        cyc, col_b, ph_b, if_b.out_col, one << 12);
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    logic [9:0]  c;
    logic [37:0] oc;
    rst_n_b = 0; if_b.out_ready = 0; @(negedge clk); rst_n_b = 1;
    en_b = 1;
    cyc = 0;
    while (!if_b.out_valid && cyc < 10) begin @(negedge clk); cyc++; end
    c = col_b; oc = if_b.out_col;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (if_b.out_valid !== 1'b1 || col_b !== c || if_b.out_col !== oc) begin
        errors++; $display("FAIL stall: got v=%b col=%0d data=%0h required v=1 col=%0d data=%0h",
          if_b.out_valid, col_b, if_b.out_col, c, oc);
      end
    end
    if_b.out_ready = 1;
    @(negedge clk);
    if_b.out_ready = 0;
    checks++;
    if (if_b.out_valid !== 1'b0 || busy_b !== 1'b1 || col_b !== c + 10'd1) begin
      errors++; $display("FAIL stall_release: got v=%b busy=%b col=%0d required v=0 busy=1 col=%0d",
        if_b.out_valid, busy_b, col_b, c + 10'd1);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (if_b.out_valid !== 1'b0 || col_b !== c + 10'd1) begin
      errors++; $display("FAIL single_handshake: got v=%b col=%0d required v=0 col=%0d",
        if_b.out_valid, col_b, c + 10'd1);
    end
    @(negedge clk);
    checks++;
    if (if_b.out_valid !== 1'b1) begin
      errors++; $display("FAIL next_column: got v=%b required 1", if_b.out_valid);
    end
    en_b = 0;
  endtask

  initial begin
    one = 38'd1;
    for (int i = 0; i < NC; i++) rom[i] = {6'($urandom), 32'($urandom)};
    rom[0] = one << 10;
    test_reset;
    test_stream;
    test_enable_drop;
    test_wave;
    test_reset_mid;
    test_backpressure;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
